piece_spawner: RTL
==================

# piece_spawner

- Produces the `tetris_pkg::active_piece_t` value that downstream logic decodes into a 4x4 grid.
- Picks piece types with a 7-bag randomizer:
  - 16-bit LFSR.
  - Every type appears exactly once per bag of 7.
- Serves spawn requests from the game controller over a pulse handshake.
- Keeps a one-piece preview queue.
- Sits between the game FSM (requester) and the active-piece register / `piece_decoder` path (consumers).

## Interface
Parameters:
- `SPAWN_X`, default 3: x field of every spawned piece (board column of the 4x4 top-left).
- `SPAWN_Y`, default 0: y field of every spawned piece.
- `LFSR_SEED`, default 16'hACE1: LFSR value loaded at reset. Must be nonzero.

Ports:
- `clk`  in  1  single clock; every register updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `spawn_req`  in  1  one-cycle request pulse for a new piece.
- `spawn_valid`  out  1  one-cycle pulse; `active_piece` is the new piece in that cycle.
- `active_piece`  out  `tetris_pkg::active_piece_t`  the spawned piece. Held stable between spawns.
- `next_type`  out  piece_type field type  preview of the queued piece.
- `preview_valid`  out  1  high when `next_type` is filled (state READY).
- `bag_mask`  out  7  bit i set means bag index i has already been drawn from the current bag.

## Operation
Index map:
- Bag indices 0..6 map to `PIECE_I, PIECE_O, PIECE_T, PIECE_L, PIECE_J, PIECE_S, PIECE_Z`.

LFSR:
- Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
- Advances every cycle in every state.

State machine:
- States are FILL, READY and DRAW. Reset enters FILL.
- FILL / DRAW: each cycle the candidate is `lfsr[2:0]`.
  - The candidate is accepted if it is not 7 and its `bag_mask` bit is clear.
  - On a rejected candidate, a 3-bit attempt counter increments.
  - After 8 consecutive rejections, the lowest clear `bag_mask` index is accepted instead.
- Accept:
  - Load `next_type`.
  - Set the mask bit. If that fills all 7 bits, clear `bag_mask` to 0 in the same cycle.
  - Clear the attempt counter.
  - Go to READY.
- READY: if `spawn_req` or `pending` is set:
  - Load `active_piece` with type = `next_type`, rotation = `ROT_0`, x = `SPAWN_X`, y = `SPAWN_Y`.
  - Assert `spawn_valid` for one cycle.
  - Clear `pending`.
  - Go to DRAW.
- A `spawn_req` arriving in FILL or DRAW sets `pending`. Further pulses while `pending` is set are dropped.
- A `spawn_req` arriving in the same cycle READY is served is consumed by that spawn. No extra pending is created.

Reset values:
- `spawn_valid` = 0, `preview_valid` = 0, `bag_mask` = 0, `pending` = 0, attempt counter = 0.
- `next_type` = `PIECE_I`.
- `active_piece` = {`PIECE_I`, `ROT_0`, `SPAWN_X`, `SPAWN_Y`}.
- LFSR = `LFSR_SEED`.
- Reset in any state, including mid-DRAW with a request pending, discards everything and returns to FILL.

## Timing
Request to spawn:
- `spawn_req` high at edge t in READY gives `spawn_valid` = 1 and the new `active_piece` during cycle t+1.
- `preview_valid` is 0 from t+1 until the refill draw is accepted.

Draw latency:
- 1 to 9 cycles (8 rejections plus the forced accept).
- READY is entered the cycle after the accepting edge.
- A pending request is served on the first READY edge.
- Worst case, request to `spawn_valid` is 10 cycles after the initial FILL.

Pulse and output rules:
- `spawn_valid` is never high on two consecutive cycles. The minimum spacing between spawns is 2 cycles.
- `active_piece` changes only on the cycle `spawn_valid` rises, and on reset.

## Configuration
- `PIECE_SPAWNER_FIXED_SEQ_EN` defined:
  - The candidate is a 3-bit counter that increments on each accept and wraps 6 to 0.
  - Spawned pieces therefore cycle I,O,T,L,J,S,Z forever.
  - The LFSR and attempt counter are still present, but their outputs are ignored.
  - Every draw takes exactly 1 cycle.
- Not defined: LFSR 7-bag behaviour as described above.

## Test plan
- FIXED_SEQ build:
  - Stimulus: reset, then 8 `spawn_req` pulses spaced 4 cycles apart.
  - Required response: `spawn_valid` types I,O,T,L,J,S,Z,I, each `ROT_0`, x=3, y=0.
  - `next_type` at each spawn is the following type.
  - `bag_mask` reads 0 after the 7th accept.
- LFSR build, 700 pulses spaced 12 cycles apart:
  - Each consecutive aligned group of 7 spawned types (the first spawn starts group 1) is a permutation of the 7 types.
  - `bag_mask` reaches 0 after every 7th accept.
  - Every request-to-`spawn_valid` gap is at most 10 cycles.
- Request during DRAW: 2 `spawn_req` pulses in consecutive DRAW cycles yield exactly 1 `spawn_valid`, on the first READY cycle. No second spawn follows.
- Back-to-back requests on every cycle for 50 cycles:
  - `spawn_valid` is never high 2 cycles in a row.
  - Spawn count equals the number of READY entries.
- Reset mid-DRAW with `pending` = 1:
  - Next cycle shows all reset values, and no `spawn_valid` occurs.
  - The subsequent spawn sequence is identical to the sequence after a cold reset (deterministic LFSR).

Source files
------------

// File: rtl/piece_spawner.sv
// piece_spawner: 7-bag piece randomizer (16-bit Galois LFSR) with a one-piece preview and pulse spawn handshake.
// Define PIECE_SPAWNER_FIXED_SEQ_EN to replace the random draw with a fixed I,O,T,L,J,S,Z cycle.
package tetris_pkg;
   typedef enum logic [2:0] {PIECE_I, PIECE_O, PIECE_T, PIECE_L, PIECE_J, PIECE_S, PIECE_Z} piece_type_t;
   typedef enum logic [1:0] {ROT_0, ROT_90, ROT_180, ROT_270} rot_t;
   typedef struct packed {
      piece_type_t ptype;
      rot_t        rot;
      logic [3:0]  x;
      logic [4:0]  y;
   } active_piece_t;
endpackage

module piece_spawner
   import tetris_pkg::*;
#(
   parameter int unsigned SPAWN_X   = 3,
   parameter int unsigned SPAWN_Y   = 0,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          spawn_req,
   output logic          spawn_valid,
   output active_piece_t active_piece,
   output piece_type_t   next_type,
   output logic          preview_valid,
   output logic [6:0]    bag_mask
);
   typedef enum logic [1:0] {FILL, READY, DRAW} state_t;

   localparam active_piece_t SPAWN_PIECE = '{ptype: PIECE_I, rot: ROT_0, x: 4'(SPAWN_X), y: 5'(SPAWN_Y)};

   state_t        state_q;
   logic [15:0]   lfsr_q, lfsr_d;
   logic [2:0]    attempt_q, pick;
   logic          force_q, pending_q, valid_q, preview_q, accept;
   logic [6:0]    mask_q, mask_set;
   piece_type_t   next_q;
   active_piece_t active_q;
`ifdef PIECE_SPAWNER_FIXED_SEQ_EN
   logic [2:0]    seq_q;
`else
   logic [2:0]    low_clear;
   logic [7:0]    taken;
`endif

   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
`ifdef PIECE_SPAWNER_FIXED_SEQ_EN
      accept = 1'b1;
      pick   = seq_q;
`else
      // bit 7 is permanently "taken" so a candidate of 7 is always rejected
      taken     = {1'b1, mask_q};
      low_clear = 3'd0;
      for (int i = 6; i >= 0; i--) if (!mask_q[i]) low_clear = 3'(i);
      accept = force_q || !taken[lfsr_q[2:0]];
      pick   = force_q ? low_clear : lfsr_q[2:0];
`endif
      mask_set = mask_q | (7'd1 << pick);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FILL;
         lfsr_q    <= LFSR_SEED;
         attempt_q <= 3'd0;
         force_q   <= 1'b0;
         pending_q <= 1'b0;
         valid_q   <= 1'b0;
         preview_q <= 1'b0;
         mask_q    <= 7'd0;
         next_q    <= PIECE_I;
         active_q  <= SPAWN_PIECE;
`ifdef PIECE_SPAWNER_FIXED_SEQ_EN
         seq_q     <= 3'd0;
`endif
      end else begin
         lfsr_q  <= lfsr_d;
         valid_q <= 1'b0;
         if (state_q == READY) begin
            if (spawn_req || pending_q) begin
               active_q       <= SPAWN_PIECE;
               active_q.ptype <= next_q;
               valid_q        <= 1'b1;
               pending_q      <= 1'b0;
               preview_q      <= 1'b0;
               state_q        <= DRAW;
            end
         end else begin
            if (spawn_req) pending_q <= 1'b1;
            if (accept) begin
               next_q    <= piece_type_t'(pick);
               mask_q    <= &mask_set ? 7'd0 : mask_set;
               attempt_q <= 3'd0;
               force_q   <= 1'b0;
               preview_q <= 1'b1;
               state_q   <= READY;
`ifdef PIECE_SPAWNER_FIXED_SEQ_EN
               seq_q     <= (seq_q == 3'd6) ? 3'd0 : seq_q + 3'd1;
`endif
            end else begin
               // eighth rejection in a row arms the forced lowest-clear pick
               attempt_q <= attempt_q + 3'd1;
               force_q   <= &attempt_q;
            end
         end
      end
   end

   assign spawn_valid   = valid_q;
   assign active_piece  = active_q;
   assign next_type     = next_q;
   assign preview_valid = preview_q;
   assign bag_mask      = mask_q;
endmodule
